addsub_arbiter: RTL
===================

Name: addsub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit adder/subtractor datapath among NREQ requesters.
- It latches the winning requester's operands and mode, drives the shared unit for WAIT_CYC cycles, then captures the sum and overflow.
- It returns the result to that requester with a one-cycle done pulse.
- It sits between client blocks (e.g. an accumulator or an address generator) and the single adder_subtractor_8bits instance.

Parameters:
- NREQ, 4, number of requesters; supported range 2..8.
- WAIT_CYC, 1, clock cycles operands are held on the unit before the result is sampled; supported range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- op_a  input  8*NREQ  operand A; requester k uses bits [8k+7:8k].
- op_b  input  8*NREQ  operand B; same packing as op_a.
- op_m  input  NREQ  mode per requester: 0 = add, 1 = subtract (A-B).
- gnt  output  NREQ  one-hot, one-cycle pulse when a request is accepted.
- done  output  NREQ  one-hot, one-cycle pulse when the result is valid.
- result  output  8  captured sum/difference; held until the next capture.
- result_ovf  output  1  captured signed overflow; held with result.
- busy  output  1  high whenever the FSM is not in IDLE.
- au_i  output  8  operand A to the shared unit.
- au_h  output  8  operand B to the shared unit.
- au_m  output  1  mode to the shared unit.
- au_s  input  8  sum returned by the shared unit.
- au_ovf  input  1  overflow returned by the shared unit.

Behaviour:
- Reset (sync, active-high) forces every output to zero: gnt, done, result, result_ovf, busy, au_i, au_h, au_m.
- Reset also sets state = IDLE, round-robin pointer ptr = 0 and wait counter = 0.
- Reset asserted mid-operation abandons the operation; no done pulse is issued.
- All outputs are registered.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - If any req bit is high, select the first requester at or after ptr, searching upward and wrapping.
  - Latch that requester's op_a slice, op_b slice and op_m bit into au_i, au_h and au_m.
  - Pulse gnt[k] for one cycle, load counter = WAIT_CYC-1 and go to EXEC.
  - If no req bit is high, stay in IDLE; au_* hold their last values.
- EXEC:
  - au_* are held stable.
  - If counter = 0: capture result <= au_s and result_ovf <= au_ovf, then go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - Pulse done[k] for the winner, set ptr = (k+1) mod NREQ and go to IDLE.
  - The next grant is issued no earlier than the cycle after RESP, so at most one operation is in flight.
- Latency with WAIT_CYC=1, taking the grant edge as cycle 0: capture at cycle 1, done at cycle 2, earliest next gnt at cycle 3.
- Throughput: one operation per WAIT_CYC+2 cycles.
- Requester protocol:
  - Hold req until gnt is seen.
  - Operands are sampled only in the grant cycle, so later changes are ignored.
  - Deassert req on or after gnt; a req still high in IDLE after done is treated as a new request.
- Simultaneous requests: exactly one gnt per grant cycle, chosen by the round-robin rule. Losers keep waiting, and none is starved; each waits at most NREQ-1 operations.
- A req that drops before it is granted is simply not served. There is no error signal.
- Arithmetic: all arithmetic is done by the external unit. This block performs no arithmetic beyond the counter and ptr increments.
- Subtraction: au_m drives both operand inversion and carry-in, so subtraction is two's complement.
- result_ovf means signed overflow as reported by the unit and is passed through unmodified.
- busy = (state != IDLE).

Test Plan:
- Reset behaviour: assert reset for 2 cycles during EXEC -> all outputs 0, state IDLE, no done pulse; the first grant after reset goes to req[0] when all req bits are high.
- Single add: req[1]=1 with A=0x25, B=0x13, m=0 -> gnt=0010 at t0, done=0010 at t0+2, result=0x38, ovf=0.
- Subtract with overflow: req[2] with A=0x80, B=0x01, m=1 -> result=0x7F, ovf=1. Also A=0x05, B=0x07, m=1 -> result=0xFE, ovf=0.
- Round-robin fairness: hold req=1111 for 8 operations -> gnt order 0,1,2,3,0,1,2,3; each done matches its gnt index and that requester's operands.
- WAIT_CYC=3 build: A=0x7F, B=0x01, m=0 -> done 4 cycles after gnt, result=0x80, ovf=1; au_* stable for the whole EXEC window; busy high from gnt until done.
- Operand change after grant: change op_a of the winner in the cycle after gnt -> result uses the operands latched at grant.

Source files
------------

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter and sequencer that time-shares one external 8-bit
// adder/subtractor between NREQ requesters, one operation in flight at a time.
module addsub_arbiter #(
  parameter int NREQ     = 4,
  parameter int WAIT_CYC = 1,
  localparam int DATA_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [DATA_W*NREQ-1:0] op_a,
  input  logic [DATA_W*NREQ-1:0] op_b,
  input  logic [NREQ-1:0]        op_m,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [DATA_W-1:0]      result,
  output logic                   result_ovf,
  output logic                   busy,
  output logic [DATA_W-1:0]      au_i,
  output logic [DATA_W-1:0]      au_h,
  output logic                   au_m,
  input  logic [DATA_W-1:0]      au_s,
  input  logic                   au_ovf
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   ai_q, ai_d;
  logic [DATA_W-1:0]   ah_q, ah_d;
  logic                am_q, am_d;

  logic                sel_vld;
  logic [PTR_W-1:0]    sel_idx;

  // Requester index base+off, wrapped into 0..NREQ-1 (NREQ need not be a power of two).
  function automatic logic [PTR_W-1:0] rr_wrap(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PTR_W'(s);
  endfunction

  // Scan from the farthest offset down so the closest requester at/after ptr wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[rr_wrap(ptr_q, i)]) begin
        sel_vld = 1'b1;
        sel_idx = rr_wrap(ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    done_d  = '0;
    res_d   = res_q;
    ovf_d   = ovf_q;
    ai_d    = ai_q;
    ah_d    = ah_q;
    am_d    = am_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          ai_d    = op_a[DATA_W*sel_idx +: DATA_W];
          ah_d    = op_b[DATA_W*sel_idx +: DATA_W];
          am_d    = op_m[sel_idx];
          gnt_d   = NREQ'(1) << sel_idx;
          win_d   = sel_idx;
          cnt_d   = CNT_INIT;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          res_d   = au_s;
          ovf_d   = au_ovf;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        done_d  = NREQ'(1) << win_q;
        ptr_d   = rr_wrap(win_q, 1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Register stage: every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      ai_q    <= '0;
      ah_q    <= '0;
      am_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      ai_q    <= ai_d;
      ah_q    <= ah_d;
      am_q    <= am_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign result     = res_q;
  assign result_ovf = ovf_q;
  assign busy       = busy_q;
  assign au_i       = ai_q;
  assign au_h       = ah_q;
  assign au_m       = am_q;

endmodule
